// File: rtl/mbox_pkg.sv
// Shared types for the memory error controller: reference FSM states and
// error-address-register codes, plus the simultaneous-error priority encoder.
package mbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_NXM  = 2'd2
    } mbox_state_t;

    typedef enum logic [1:0] {
        ERA_NONE = 2'b00,
        ERA_NXM  = 2'b01,
        ERA_APE  = 2'b10,
        ERA_DPE  = 2'b11
    } era_code_t;

    // Data parity outranks address parity, which outranks NXM.
    function automatic era_code_t era_encode(input logic i_dpe, input logic i_ape, input logic i_nxm);
        era_code_t code;
        if (i_dpe)
            code = ERA_DPE;
        else if (i_ape)
            code = ERA_APE;
        else if (i_nxm)
            code = ERA_NXM;
        else
            code = ERA_NONE;
        return code;
    endfunction

endpackage

// File: rtl/nxm_timer.sv
// Saturating up-counter used both to time a reference for NXM and to
// stretch BUSY after an NXM is declared.
module nxm_timer #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            RESET_n,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [TO_W-1:0] o_count
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en && (r_count != '1))
            r_count <= r_count + TO_W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_err_ctl.sv
// Memory reference controller: tracks one reference at a time, declares NXM
// on timeout, and keeps sticky NXM flags plus a freezing error address register.
module mem_err_ctl
    import mbox_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int AW          = 22,
    parameter int TO_W        = 8,
    parameter int NXM_STRETCH = 4,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            RESET_n,
    input  logic            START,
    input  logic [IDW-1:0]  REQ_ID,
    input  logic [AW-1:0]   ADR,
    input  logic            WRITE,
    input  logic            ACKN,
    input  logic            ADR_PAR_ERR_IN,
    input  logic            DATA_PAR_ERR_IN,
    input  logic [TO_W-1:0] TIMEOUT,
    input  logic            ERR_CLR,
    input  logic [NREQ-1:0] ERR_CLR_MASK,
    output logic            BUSY,
    output logic            NXM_DATA_VAL,
    output logic [NREQ-1:0] NXM_ERR,
    output logic            ERR_HOLD,
    output logic [AW-1:0]   ERA_ADR,
    output logic [IDW-1:0]  ERA_ID,
    output logic            ERA_WRITE,
    output logic [1:0]      ERA_CODE,
    output logic [1:0]      DBG_STATE,
    output logic [TO_W-1:0] DBG_COUNT
);

    localparam logic [TO_W-1:0] STR_LAST = TO_W'(NXM_STRETCH - 1);
    localparam logic [TO_W-1:0] STR_PRE  = TO_W'((NXM_STRETCH > 1) ? NXM_STRETCH - 2 : 0);
    localparam logic [NREQ-1:0] ONE_REQ  = NREQ'(1);

    mbox_state_t     r_state;
    mbox_state_t     w_state_nxt;
    logic [AW-1:0]   r_ref_adr;
    logic [IDW-1:0]  r_ref_id;
    logic            r_ref_write;
    logic            r_nxm_dv;
    logic [NREQ-1:0] r_nxm_err;
    logic            r_err_hold;
    logic [AW-1:0]   r_era_adr;
    logic [IDW-1:0]  r_era_id;
    logic            r_era_write;
    era_code_t       r_era_code;

    logic [TO_W-1:0] w_count;
    logic            w_start_acc;
    logic            w_in_wait;
    logic            w_timeout_hit;
    logic            w_stretch_done;
    logic            w_ape;
    logic            w_dpe;
    era_code_t       w_err_code;
    logic            w_err_any;
    logic            w_era_open;
    logic            w_dv_next;

    // Protocol: START is a one-cycle request honoured only in IDLE; ACKN is a
    // one-cycle completion honoured only in WAIT. Neither is ever back-pressured.
    assign w_start_acc    = START && (r_state == ST_IDLE);
    assign w_in_wait      = (r_state == ST_WAIT);
    assign w_timeout_hit  = w_in_wait && !ACKN && (TIMEOUT != '0) && (w_count == TIMEOUT - TO_W'(1));
    assign w_stretch_done = (r_state == ST_NXM) && (w_count == STR_LAST);
    assign w_ape          = w_start_acc && ADR_PAR_ERR_IN;
    assign w_dpe          = w_in_wait && ACKN && !r_ref_write && DATA_PAR_ERR_IN;
    assign w_err_code     = era_encode(w_dpe, w_ape, w_timeout_hit);
    assign w_err_any      = (w_err_code != ERA_NONE);
    // A clear coincident with a new event releases the freeze first, so the new event is recorded.
    assign w_era_open     = !r_err_hold || ERR_CLR;
    assign w_dv_next      = !r_ref_write &&
                            (((NXM_STRETCH == 1) && w_timeout_hit) ||
                             ((NXM_STRETCH > 1) && (r_state == ST_NXM) && (w_count == STR_PRE)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (ACKN)
                    w_state_nxt = ST_IDLE;
                else if (w_timeout_hit)
                    w_state_nxt = ST_NXM;
            end
            ST_NXM:  if (w_stretch_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    nxm_timer #(.TO_W(TO_W)) u_timer (
        .clk     (clk),
        .RESET_n (RESET_n),
        .i_clr   (w_start_acc || w_timeout_hit),
        .i_en    (r_state != ST_IDLE),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= ST_IDLE;
            r_ref_adr   <= '0;
            r_ref_id    <= '0;
            r_ref_write <= 1'b0;
            r_nxm_dv    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_nxm_dv <= w_dv_next;
            if (w_start_acc) begin
                r_ref_adr   <= ADR;
                r_ref_id    <= REQ_ID;
                r_ref_write <= WRITE;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_nxm_err   <= '0;
            r_err_hold  <= 1'b0;
            r_era_adr   <= '0;
            r_era_id    <= '0;
            r_era_write <= 1'b0;
            r_era_code  <= ERA_NONE;
        end else begin
            r_nxm_err <= (r_nxm_err & ~(ERR_CLR ? ERR_CLR_MASK : '0)) |
                         (w_timeout_hit ? (ONE_REQ << r_ref_id) : '0);
            if (w_err_any && w_era_open) begin
                r_err_hold  <= 1'b1;
                r_era_code  <= w_err_code;
                r_era_adr   <= w_start_acc ? ADR : r_ref_adr;
                r_era_id    <= w_start_acc ? REQ_ID : r_ref_id;
                r_era_write <= w_start_acc ? WRITE : r_ref_write;
            end else begin
                if (ERR_CLR) begin
                    r_err_hold <= 1'b0;
                    r_era_code <= ERA_NONE;
                end
                if (w_start_acc && w_era_open) begin
                    r_era_adr   <= ADR;
                    r_era_id    <= REQ_ID;
                    r_era_write <= WRITE;
                    r_era_code  <= ERA_NONE;
                end
            end
        end
    end

    assign BUSY         = (r_state != ST_IDLE);
    assign NXM_DATA_VAL = r_nxm_dv;
    assign NXM_ERR      = r_nxm_err;
    assign ERR_HOLD     = r_err_hold;
    assign ERA_ADR      = r_era_adr;
    assign ERA_ID       = r_era_id;
    assign ERA_WRITE    = r_era_write;
    assign ERA_CODE     = r_era_code;
    assign DBG_STATE    = r_state;
    assign DBG_COUNT    = w_count;

endmodule

// File: tb/tb_mem_err_ctl.sv
// Bench for mem_err_ctl: a vector table, directed multi-cycle sequences, and
// randomized traffic checked against a reference-level behavioural model.
module tb_mem_err_ctl;
    import mbox_pkg::*;

    localparam int NXM_STRETCH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  req_id;
    logic [21:0] adr;
    logic        write;
    logic        ackn;
    logic        ape_in;
    logic        dpe_in;
    logic [7:0]  timeout;
    logic        err_clr;
    logic [3:0]  clr_mask;
    logic        busy;
    logic        nxm_dv;
    logic [3:0]  nxm_err;
    logic        err_hold;
    logic [21:0] era_adr;
    logic [1:0]  era_id;
    logic        era_write;
    logic [1:0]  era_code;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_count;

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];

    mem_err_ctl #(.NREQ(4), .AW(22), .TO_W(8), .NXM_STRETCH(NXM_STRETCH)) dut (
        .clk(clk), .RESET_n(rst_n), .START(start), .REQ_ID(req_id), .ADR(adr),
        .WRITE(write), .ACKN(ackn), .ADR_PAR_ERR_IN(ape_in), .DATA_PAR_ERR_IN(dpe_in),
        .TIMEOUT(timeout), .ERR_CLR(err_clr), .ERR_CLR_MASK(clr_mask),
        .BUSY(busy), .NXM_DATA_VAL(nxm_dv), .NXM_ERR(nxm_err), .ERR_HOLD(err_hold),
        .ERA_ADR(era_adr), .ERA_ID(era_id), .ERA_WRITE(era_write), .ERA_CODE(era_code),
        .DBG_STATE(dbg_state), .DBG_COUNT(dbg_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one reference in flight, aged in WAIT cycles.
    bit          m_in_wait;
    int          m_age;
    int          m_nxm_left;
    logic        m_rw;
    logic [1:0]  m_rid;
    logic [21:0] m_radr;
    logic        m_dv;
    logic [3:0]  m_nxm;
    logic        m_hold;
    logic [21:0] m_eadr;
    logic [1:0]  m_eid;
    logic        m_ewr;
    logic [1:0]  m_ecode;

    task automatic model_reset();
        m_in_wait = 0; m_age = 0; m_nxm_left = 0;
        m_rw = 0; m_rid = 0; m_radr = 0;
        m_dv = 0; m_nxm = 0; m_hold = 0;
        m_eadr = 0; m_eid = 0; m_ewr = 0; m_ecode = 0;
    endtask

    task automatic model_step();
        logic acc = 0;
        logic ape = 0;
        logic dpe = 0;
        logic nxm = 0;
        logic open;
        logic [1:0] code;
        open = !m_hold || err_clr;
        if (!m_in_wait && m_nxm_left == 0) begin
            if (start) begin
                acc = 1; ape = ape_in;
                m_rid = req_id; m_radr = adr; m_rw = write;
                m_in_wait = 1; m_age = 0;
            end
        end else if (m_in_wait) begin
            m_age++;
            if (ackn) begin
                m_in_wait = 0;
                dpe = !m_rw && dpe_in;
            end else if (timeout != 0 && m_age == int'(timeout)) begin
                nxm = 1; m_in_wait = 0; m_nxm_left = NXM_STRETCH;
            end
        end else begin
            m_nxm_left--;
        end
        m_dv = (m_nxm_left == 1) && !m_rw;
        code = dpe ? 2'd3 : ape ? 2'd2 : nxm ? 2'd1 : 2'd0;
        if (err_clr) m_nxm = m_nxm & ~clr_mask;
        if (nxm) m_nxm[m_rid] = 1'b1;
        if (code != 0 && open) begin
            m_hold = 1; m_ecode = code;
            m_eadr = m_radr; m_eid = m_rid; m_ewr = m_rw;
        end else begin
            if (err_clr) begin m_hold = 0; m_ecode = 0; end
            if (acc && open) begin
                m_eadr = m_radr; m_eid = m_rid; m_ewr = m_rw; m_ecode = 0;
            end
        end
    endtask

    function automatic logic [33:0] model_vec();
        logic m_busy;
        m_busy = m_in_wait || (m_nxm_left > 0);
        return {m_busy, m_dv, m_nxm, m_hold, m_eadr, m_eid, m_ewr, m_ecode};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {busy, nxm_dv, nxm_err, err_hold, era_adr, era_id, era_write, era_code};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        start = 0; req_id = 0; adr = 0; write = 0; ackn = 0;
        ape_in = 0; dpe_in = 0; err_clr = 0; clr_mask = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_outputs", 64'(dut_vec()), 64'd0);
        chk("reset_count", 64'(dbg_count), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drv_start(input logic [1:0] id, input logic [21:0] a, input logic wr, input logic pe);
        start = 1; req_id = id; adr = a; write = wr; ape_in = pe;
        tick();
        drive_idle();
    endtask

    task automatic drv_ack(input logic pe, input logic clr, input logic [3:0] mask);
        ackn = 1; dpe_in = pe; err_clr = clr; clr_mask = mask;
        tick();
        drive_idle();
    endtask

    typedef struct {
        logic        start;
        logic [1:0]  id;
        logic [21:0] adr;
        logic        wr;
        logic        ack;
        logic        ape;
        logic        dpe;
        logic        clr;
        logic [3:0]  mask;
        logic [33:0] expv;
    } vec_t;

    function automatic vec_t mk(input int s, input int id, input int a, input int wr, input int ack,
                                input int ape, input int dpe, input int clr, input int mask,
                                input int b, input int dv, input int nx, input int h, input int c,
                                input int eid, input int eadr, input int ewr);
        vec_t v;
        v.start = s[0]; v.id = id[1:0]; v.adr = a[21:0]; v.wr = wr[0]; v.ack = ack[0];
        v.ape = ape[0]; v.dpe = dpe[0]; v.clr = clr[0]; v.mask = mask[3:0];
        v.expv = {b[0], dv[0], nx[3:0], h[0], eadr[21:0], eid[1:0], ewr[0], c[1:0]};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int idx;
        int busy_n;
        int dv_n;
        int nxm_idx;
        logic [33:0] e;

        drive_idle();
        timeout = 8'd3;
        apply_reset();

        // Table: TIMEOUT=3, stretch 4
        //                s id adr    wr ak ape dpe clr mask  busy dv nxm hold code id eadr  ewr
        tbl.push_back(mk(1, 1, 'h100, 1, 0, 0,  0,  0,  0,    1,   0, 0,  0,   0,   1, 'h100, 1));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 0,  0,   0,   1, 'h100, 1));
        tbl.push_back(mk(0, 0, 0,     0, 1, 0,  0,  0,  0,    0,   0, 0,  0,   0,   1, 'h100, 1));
        tbl.push_back(mk(1, 2, 'h200, 0, 0, 1,  0,  0,  0,    1,   0, 0,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 0,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 0,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 4,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 4,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   0, 4,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    1,   1, 4,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  0,  0,    0,   0, 4,  1,   2,   2, 'h200, 0));
        tbl.push_back(mk(1, 3, 'h300, 1, 1, 0,  0,  1,  4,    1,   0, 0,  0,   0,   3, 'h300, 1));
        tbl.push_back(mk(0, 0, 0,     0, 1, 0,  1,  0,  0,    0,   0, 0,  0,   0,   3, 'h300, 1));
        tbl.push_back(mk(1, 0, 'h0AA, 0, 0, 0,  0,  0,  0,    1,   0, 0,  0,   0,   0, 'h0AA, 0));
        tbl.push_back(mk(1, 1, 'h111, 1, 0, 0,  0,  0,  0,    1,   0, 0,  0,   0,   0, 'h0AA, 0));
        tbl.push_back(mk(0, 0, 0,     0, 1, 0,  1,  0,  0,    0,   0, 0,  1,   3,   0, 'h0AA, 0));
        tbl.push_back(mk(1, 2, 'h222, 0, 0, 0,  0,  0,  0,    1,   0, 0,  1,   3,   0, 'h0AA, 0));
        tbl.push_back(mk(0, 0, 0,     0, 1, 0,  0,  0,  0,    0,   0, 0,  1,   3,   0, 'h0AA, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,  0,  1,  15,   0,   0, 0,  0,   0,   0, 'h0AA, 0));
        foreach (tbl[i]) begin
            start = tbl[i].start; req_id = tbl[i].id; adr = tbl[i].adr; write = tbl[i].wr;
            ackn = tbl[i].ack; ape_in = tbl[i].ape; dpe_in = tbl[i].dpe;
            err_clr = tbl[i].clr; clr_mask = tbl[i].mask;
            tick();
            chk($sformatf("tbl_row%0d", i), 64'(dut_vec()), 64'(tbl[i].expv));
            drive_idle();
        end

        // Read NXM with TIMEOUT=8
        timeout = 8'd8;
        apply_reset();
        drv_start(2'd2, 22'o1234, 1'b0, 1'b0);
        idx = 0; busy_n = 0; dv_n = 0; nxm_idx = -1;
        while (busy && idx < 40) begin
            if (nxm_dv) dv_n++;
            if (nxm_err != 0 && nxm_idx < 0) nxm_idx = idx;
            busy_n++;
            tick();
            idx++;
        end
        chk("nxm_busy_cycles", 64'(busy_n), 64'd12);
        chk("nxm_dv_pulses", 64'(dv_n), 64'd1);
        chk("nxm_detect_cycle", 64'(nxm_idx), 64'd8);
        chk("nxm_flags", 64'(nxm_err), 64'b0100);
        chk("nxm_era_code", 64'(era_code), 64'd1);
        chk("nxm_era_adr", 64'(era_adr), 64'o1234);
        chk("nxm_era_id", 64'(era_id), 64'd2);
        chk("nxm_hold", 64'(err_hold), 64'd1);

        // ACKN on the 8th WAIT cycle beats the timeout
        apply_reset();
        drv_start(2'd1, 22'h55, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick();
        chk("ack8_busy_before", 64'(busy), 64'd1);
        drv_ack(1'b0, 1'b0, 4'd0);
        chk("ack8_busy_after", 64'(busy), 64'd0);
        chk("ack8_hold", 64'(err_hold), 64'd0);
        tick();
        chk("ack8_no_nxm", 64'({nxm_err, nxm_dv, busy}), 64'd0);

        // APE from id1 then NXM from id3: ERA keeps the first error
        timeout = 8'd4;
        apply_reset();
        drv_start(2'd1, 22'h41, 1'b1, 1'b1);
        drv_ack(1'b0, 1'b0, 4'd0);
        drv_start(2'd3, 22'h33, 1'b0, 1'b0);
        for (int k = 0; k < 30 && busy; k++) tick();
        chk("two_err_idle", 64'(busy), 64'd0);
        chk("two_err_era", 64'({era_id, era_code, era_adr}), 64'({2'd1, 2'd2, 22'h41}));
        chk("two_err_flags", 64'(nxm_err), 64'b1000);
        err_clr = 1; clr_mask = 4'b1000;
        tick();
        drive_idle();
        chk("two_err_clr", 64'({nxm_err, err_hold, era_code}), 64'd0);

        // TIMEOUT=0: no NXM ever, counter saturates, reset aborts
        timeout = 8'd0;
        apply_reset();
        drv_start(2'd0, 22'h7, 1'b0, 1'b0);
        busy_n = 0; dv_n = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy) busy_n++;
            if (nxm_dv) dv_n++;
            tick();
        end
        chk("to0_busy", 64'(busy_n), 64'd300);
        chk("to0_no_nxm", 64'({nxm_err, dv_n[3:0]}), 64'd0);
        chk("to0_sat", 64'(dbg_count), 64'hFF);
        apply_reset();
        drv_start(2'd2, 22'h77, 1'b1, 1'b0);
        chk("post_reset_start", 64'({busy, era_id, era_code}), 64'({1'b1, 2'd2, 2'd0}));

        // DPE coincident with ERR_CLR while ERA is held
        timeout = 8'd8;
        apply_reset();
        drv_start(2'd1, 22'h10, 1'b1, 1'b1);
        drv_ack(1'b0, 1'b0, 4'd0);
        drv_start(2'd2, 22'h99, 1'b0, 1'b0);
        drv_ack(1'b1, 1'b1, 4'd0);
        chk("dpe_clr_hold", 64'(err_hold), 64'd1);
        chk("dpe_clr_code", 64'(era_code), 64'd3);

        // Randomized traffic against the model
        apply_reset();
        for (int chunk = 0; chunk < 5; chunk++) begin
            timeout = 8'($urandom_range(0, 6));
            for (int k = 0; k < 120; k++) begin
                start = ($urandom_range(0, 99) < 35);
                req_id = 2'($urandom_range(0, 3));
                adr = 22'($urandom);
                write = $urandom_range(0, 1) == 1;
                ackn = ($urandom_range(0, 99) < 25);
                ape_in = ($urandom_range(0, 99) < 15);
                dpe_in = ($urandom_range(0, 99) < 30);
                err_clr = ($urandom_range(0, 99) < 8);
                clr_mask = 4'($urandom);
                tick();
                exp_q.push_back(model_vec());
                e = exp_q.pop_front();
                chk($sformatf("rand_c%0d_k%0d", chunk, k), 64'(dut_vec()), 64'(e));
            end
        end
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
